inst_display_scan: RTL and testbench

//  Parametrised instruction-fetch-and-display unit for the board-level debug path.

---
 rtl/inst_display_scan.sv | 128 ++++++++++++
 tb/tb_inst_display_scan.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_display_scan.sv
// Instruction fetch-and-display unit for the board debug path.
// Walks a program counter through an external synchronous ROM, latches each
// fetched word, and shows one LED-wide slice of it. The slice comes from the
// switches or from a free-running rotator.
module inst_display_scan #(
  parameter int INST_W  = 32,
  parameter int LED_W   = 8,
  parameter int SEL_W   = 2,
  parameter int ADDR_W  = 6,
  parameter int DEPTH   = 64,
  parameter int ROM_LAT = 1,
  parameter int ROT_DIV = 50_000_000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Step,
  input  logic              Mode,
  input  logic [SEL_W-1:0]  Sel,
  output logic [ADDR_W-1:0] Rom_Addr,
  input  logic [INST_W-1:0] Rom_Data,
  output logic [INST_W-1:0] Inst_Code,
  output logic [ADDR_W-1:0] Pc,
  output logic [SEL_W-1:0]  Slice_Idx,
  output logic [LED_W-1:0]  LED,
  output logic              Busy,
  output logic              Valid
);

  localparam int NSLICE = INST_W / LED_W;
  localparam int LAT_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam int DIV_W  = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t             state;
  state_t             state_next;
  logic               take_step;
  logic               fetch_done;
  logic [LAT_W-1:0]   lat_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic [SEL_W-1:0]   rot;
  logic               mode_q;
  logic [ADDR_W-1:0]  pc_next;

  // The ROM address is the program counter itself, already registered.
  assign Rom_Addr = Pc;

  // Successor address, wrapping after the last valid ROM word.
  assign pc_next = (Pc == ADDR_W'(DEPTH - 1)) ? '0 : Pc + 1'b1;

  // Next-state logic: accept Step only from IDLE, finish a fetch once the ROM latency has elapsed.
  always_comb begin
    state_next = state;
    take_step  = 1'b0;
    fetch_done = 1'b0;
    case (state)
      IDLE: begin
        if (Step) begin
          take_step  = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (lat_cnt == LAT_W'(ROM_LAT - 1)) begin
          fetch_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // State, PC and instruction latch; reset lands in FETCH so word 0 is loaded automatically.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= FETCH;
      lat_cnt   <= '0;
      Pc        <= '0;
      Inst_Code <= '0;
      Valid     <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      state <= state_next;
      Busy  <= (state_next == FETCH);
      if (take_step) begin
        Pc      <= pc_next;
        Valid   <= 1'b0;
        lat_cnt <= '0;
      end else if (state == FETCH && !fetch_done) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
      if (fetch_done) begin
        Inst_Code <= Rom_Data;
        Valid     <= 1'b1;
      end
    end
  end

  // Slice rotator: held at zero until Mode has been high for a full cycle, then steps every ROT_DIV cycles.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mode_q  <= 1'b0;
      div_cnt <= '0;
      rot     <= '0;
    end else begin
      mode_q <= Mode;
      if (!Mode || !mode_q) begin
        div_cnt <= '0;
        rot     <= '0;
      end else if (div_cnt == DIV_W'(ROT_DIV - 1)) begin
        div_cnt <= '0;
        rot     <= (rot == SEL_W'(NSLICE - 1)) ? '0 : rot + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Slice selection and LED mux; indices past the last slice show a dark bank.
  always_comb begin
    Slice_Idx = Mode ? rot : Sel;
    LED       = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (Slice_Idx == SEL_W'(i)) LED = Inst_Code[i*LED_W +: LED_W];
    end
  end

endmodule

// File: tb/tb_inst_display_scan.sv
// Self-checking bench for inst_display_scan: directed scenarios plus random
// stimulus, all outputs compared every cycle against a behavioural model.
module tb_inst_display_scan;

  localparam int INST_W  = 32;
  localparam int LED_W   = 8;
  localparam int SEL_W   = 3;
  localparam int ADDR_W  = 3;
  localparam int DEPTH   = 5;
  localparam int ROM_LAT = 3;
  localparam int ROT_DIV = 4;
  localparam int NSLICE  = INST_W / LED_W;

  logic              clk;
  logic              rst_n;
  logic              step;
  logic              mode;
  logic [SEL_W-1:0]  sel;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_data;
  logic [INST_W-1:0] inst_code;
  logic [ADDR_W-1:0] pc;
  logic [SEL_W-1:0]  slice_idx;
  logic [LED_W-1:0]  led;
  logic              busy;
  logic              valid;

  int checks;
  int errors;
  bit check_en;

  logic [INST_W-1:0] rom [0:DEPTH-1];
  logic [INST_W-1:0] rom_pipe [0:ROM_LAT-2];

  int          m_pc;
  int          m_left;
  logic [31:0] m_inst;
  bit          m_valid;
  bit          m_busy;
  int          m_k;
  bit          m_prev_mode;

  inst_display_scan #(
    .INST_W(INST_W), .LED_W(LED_W), .SEL_W(SEL_W), .ADDR_W(ADDR_W),
    .DEPTH(DEPTH), .ROM_LAT(ROM_LAT), .ROT_DIV(ROT_DIV)
  ) dut (
    .Clk(clk), .Rst(rst_n), .Step(step), .Mode(mode), .Sel(sel),
    .Rom_Addr(rom_addr), .Rom_Data(rom_data), .Inst_Code(inst_code),
    .Pc(pc), .Slice_Idx(slice_idx), .LED(led), .Busy(busy), .Valid(valid)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM: data for an address is ready to be sampled ROM_LAT edges after it appears.
  always @(posedge clk) begin
    rom_pipe[0] <= rom[rom_addr];
    for (int i = 1; i < ROM_LAT - 1; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-2];

  // Reference model: fetch countdown, word latch, and rotation from cycles spent in auto mode.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc        = 0;
      m_left      = ROM_LAT;
      m_inst      = '0;
      m_valid     = 1'b0;
      m_busy      = 1'b0;
      m_k         = 0;
      m_prev_mode = 1'b0;
    end else begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_inst  = rom[m_pc];
          m_valid = 1'b1;
        end
      end else if (step) begin
        m_pc    = (m_pc + 1) % DEPTH;
        m_valid = 1'b0;
        m_left  = ROM_LAT;
      end
      m_busy = (m_left > 0);
      if (mode && m_prev_mode) m_k++;
      else m_k = 0;
      m_prev_mode = mode;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One cycle of stimulus, driven just after the rising edge.
  task automatic applyStimulus(input logic s, input logic m, input logic [SEL_W-1:0] sl);
    @(posedge clk);
    #1;
    step = s;
    mode = m;
    sel  = sl;
  endtask

  // Every falling edge: compare all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      int          idx;
      logic [31:0] exp_led;
      idx     = mode ? (m_k / ROT_DIV) % NSLICE : int'(sel);
      exp_led = (idx < NSLICE) ? ((m_inst >> (idx * LED_W)) & 32'hFF) : 32'h0;
      checkOutput("pc",        32'(pc),        32'(m_pc));
      checkOutput("rom_addr",  32'(rom_addr),  32'(m_pc));
      checkOutput("valid",     32'(valid),     32'(m_valid));
      checkOutput("busy",      32'(busy),      32'(m_busy));
      checkOutput("inst_code", inst_code,      m_inst);
      checkOutput("slice_idx", 32'(slice_idx), 32'(idx));
      checkOutput("led",       32'(led),       exp_led);
    end
  end

  initial begin
    logic [7:0] rot_bytes [0:3];
    rot_bytes[0] = 8'hDD;
    rot_bytes[1] = 8'hCC;
    rot_bytes[2] = 8'hBB;
    rot_bytes[3] = 8'hAA;
    checks   = 0;
    errors   = 0;
    check_en = 1'b0;
    rom[0] = 32'h12345678;
    rom[1] = 32'hDEADBEEF;
    rom[2] = 32'hAABBCCDD;
    for (int i = 3; i < DEPTH; i++) rom[i] = $urandom;
    step  = 1'b0;
    mode  = 1'b0;
    sel   = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    check_en = 1'b1;
    #1;
    checkOutput("reset_pc",    32'(pc),    32'h0);
    checkOutput("reset_valid", 32'(valid), 32'h0);
    checkOutput("reset_led",   32'(led),   32'h0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    rst_n = 1'b1;

    // Auto-fetch of word 0 after reset release.
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    #1 checkOutput("boot_valid_early", 32'(valid), 32'h0);
    applyStimulus(0, 0, 0);
    #1 checkOutput("boot_valid", 32'(valid), 32'h1);
    checkOutput("boot_led_s0", 32'(led), 32'h78);
    applyStimulus(0, 0, 3);
    #1 checkOutput("boot_led_s3", 32'(led), 32'h12);

    // Single step to word 1.
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 2);
    #1 checkOutput("step_pc", 32'(pc), 32'h1);
    checkOutput("step_busy", 32'(busy), 32'h1);
    applyStimulus(0, 0, 2);
    applyStimulus(0, 0, 2);
    #1 checkOutput("step_busy_last", 32'(busy), 32'h1);
    checkOutput("step_valid_low", 32'(valid), 32'h0);
    applyStimulus(0, 0, 2);
    #1 checkOutput("step_inst", inst_code, 32'hDEADBEEF);
    checkOutput("step_led_s2", 32'(led), 32'hAD);
    checkOutput("step_busy_done", 32'(busy), 32'h0);

    // Step during a fetch is dropped.
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    #1 checkOutput("ignore_pc", 32'(pc), 32'h2);
    checkOutput("ignore_valid", 32'(valid), 32'h0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    #1 checkOutput("ignore_inst", inst_code, 32'hAABBCCDD);
    checkOutput("ignore_pc_after", 32'(pc), 32'h2);

    // Auto-rotate through the four slices.
    applyStimulus(0, 1, 0);
    #1 checkOutput("rot_pre", 32'(led), 32'hDD);
    for (int j = 0; j <= 16; j++) begin
      applyStimulus(0, 1, 0);
      #1 checkOutput("rot_led", 32'(led), 32'(rot_bytes[(j / ROT_DIV) % NSLICE]));
    end
    applyStimulus(0, 0, 0);

    // Reset in the middle of a fetch.
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    #2 rst_n = 1'b0;
    #1 checkOutput("abort_pc", 32'(pc), 32'h0);
    checkOutput("abort_valid", 32'(valid), 32'h0);
    checkOutput("abort_led", 32'(led), 32'h0);
    applyStimulus(0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    #1 checkOutput("abort_refetch", inst_code, 32'h12345678);
    checkOutput("abort_refetch_valid", 32'(valid), 32'h1);

    // Random traffic: steps, mode changes, any select value, occasional reset.
    begin
      logic m;
      m = 1'b0;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 19) == 0) m = ~m;
        applyStimulus(logic'($urandom_range(0, 2) == 0), m, SEL_W'($urandom_range(0, 7)));
        rst_n = 1'b1;
        if ($urandom_range(0, 79) == 0) #2 rst_n = 1'b0;
      end
      applyStimulus(0, 0, 0);
      rst_n = 1'b1;
      applyStimulus(0, 0, 0);
    end

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
